// File: rtl/led_pattern_sequencer.sv
// Autonomous LED pattern animator: rotate/bounce a seed pattern at a prescaled step rate,
// with a one-cycle load handshake that resets the step state.
module led_pattern_sequencer #(
  parameter int                 WIDTH         = 18,
  parameter int                 SLOW_DIV      = 25000000,
  parameter int                 FAST_DIV      = 6250000,
  parameter logic [WIDTH-1:0]   RESET_PATTERN = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [1:0]       modes_export,
  input  logic             spcont_export,
  input  logic             run,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic [WIDTH-1:0] pattern_export,
  output logic             step_pulse,
  output logic             dir,
  output logic [7:0]       step_count
);

  localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CNT_W   = $clog2(MAX_DIV);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LOAD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             dir_q, dir_d;
  logic             pulse_q, pulse_d;
  logic [7:0]       scnt_q, scnt_d;
  logic [CNT_W-1:0] div_m1;
  logic             tick;
  logic             accept;

  assign div_m1     = spcont_export ? CNT_W'(FAST_DIV - 1) : CNT_W'(SLOW_DIV - 1);
  // >= rather than == so a slow->fast switch with cnt already past the fast limit ticks at once.
  assign tick       = (state_q == S_RUN) && (cnt_q >= div_m1);
  assign load_ready = (state_q != S_LOAD);
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pat_q   <= RESET_PATTERN;
      dir_q   <= 1'b0;
      pulse_q <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      pulse_q <= pulse_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pat_d   = pat_q;
    dir_d   = dir_q;
    pulse_d = 1'b0;
    scnt_d  = scnt_q;

    unique case (state_q)
      S_IDLE: if (run) state_d = S_RUN;
      S_RUN: begin
        if (!run)       state_d = S_IDLE;
        else if (!tick) cnt_d   = cnt_q + CNT_W'(1);
      end
      S_LOAD:  state_d = run ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (tick && !accept && (modes_export != 2'b00)) begin
      pulse_d = 1'b1;
      scnt_d  = scnt_q + 8'd1;
      unique case (modes_export)
        2'b01: pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
        2'b10: pat_d = {pat_q[0], pat_q[WIDTH-1:1]};
        default: begin
          // Reverse at the end bit; an all-zero pattern never hits either end.
          if (!dir_q && pat_q[WIDTH-1]) begin
            dir_d = 1'b1;
            pat_d = pat_q >> 1;
          end else if (dir_q && pat_q[0]) begin
            dir_d = 1'b0;
            pat_d = pat_q << 1;
          end else begin
            pat_d = dir_q ? (pat_q >> 1) : (pat_q << 1);
          end
        end
      endcase
    end

    if (accept) begin
      state_d = S_LOAD;
      cnt_d   = '0;
      pat_d   = load_data;
      dir_d   = 1'b0;
      scnt_d  = '0;
      pulse_d = 1'b0;
    end
  end

  assign pattern_export = pat_q;
  assign step_pulse     = pulse_q;
  assign dir            = dir_q;
  assign step_count     = scnt_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: table of stimulus segments with hand-derived end values,
// plus a cycle model feeding a scoreboard queue that is checked after every edge.
module tb_led_pattern_sequencer;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   modes;
  logic         sp;
  logic         run_i;
  logic         lv;
  logic [W-1:0] ld;
  logic         rdy;
  logic [W-1:0] pat;
  logic         pulse;
  logic         dir_o;
  logic [7:0]   scnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .WIDTH(W), .SLOW_DIV(8), .FAST_DIV(2), .RESET_PATTERN(18'h00001)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .modes_export(modes), .spcont_export(sp),
    .run(run_i), .load_valid(lv), .load_data(ld), .load_ready(rdy),
    .pattern_export(pat), .step_pulse(pulse), .dir(dir_o), .step_count(scnt)
  );

  typedef struct {
    bit           is_load;
    int           ncyc;
    logic [1:0]   mode;
    logic         sp;
    logic         run;
    logic [W-1:0] data;
    logic [W-1:0] e_pat;
    logic [7:0]   e_cnt;
    logic         e_dir;
  } vec_t;

  typedef struct {
    logic [W-1:0] pat;
    logic         pulse;
    logic         dir;
    logic         rdy;
    logic [7:0]   cnt;
  } obs_t;

  typedef enum {M_IDLE, M_RUN, M_LOAD} mst_t;

  vec_t tbl[$];
  obs_t sbq[$];

  mst_t         m_st;
  int           m_cnt;
  logic [W-1:0] m_pat;
  logic         m_dir;
  logic         m_pulse;
  logic [7:0]   m_sc;

  function automatic vec_t mk(bit l, int n, logic [1:0] m, logic s, logic r, logic [W-1:0] d,
                              logic [W-1:0] ep, logic [7:0] ec, logic ed);
    vec_t v;
    v.is_load = l; v.ncyc = n; v.mode = m; v.sp = s; v.run = r; v.data = d;
    v.e_pat = ep; v.e_cnt = ec; v.e_dir = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_cnt = 0; m_pat = 18'h00001; m_dir = 1'b0; m_pulse = 1'b0; m_sc = 8'd0;
  endtask

  task automatic model_step();
    int           lim;
    bit           tk;
    logic [W-1:0] p;
    lim = sp ? 2 : 8;
    tk  = (m_st == M_RUN) && (m_cnt >= lim - 1);
    p   = m_pat;
    m_pulse = 1'b0;
    if (lv && m_st != M_LOAD) begin
      m_pat = ld; m_dir = 1'b0; m_sc = 8'd0; m_cnt = 0; m_st = M_LOAD;
    end else begin
      if (tk && modes != 2'b00) begin
        m_pulse = 1'b1;
        m_sc    = m_sc + 8'd1;
        if (modes == 2'b01)      m_pat = {p[W-2:0], p[W-1]};
        else if (modes == 2'b10) m_pat = {p[0], p[W-1:1]};
        else begin
          if (m_dir == 1'b0 && p[W-1])  m_dir = 1'b1;
          else if (m_dir == 1'b1 && p[0]) m_dir = 1'b0;
          m_pat = m_dir ? (p >> 1) : (p << 1);
        end
      end
      m_cnt = (m_st == M_RUN && run_i && !tk) ? m_cnt + 1 : 0;
      m_st  = run_i ? M_RUN : M_IDLE;
    end
  endtask

  task automatic cycle();
    obs_t e;
    model_step();
    e.pat = m_pat; e.pulse = m_pulse; e.dir = m_dir; e.rdy = (m_st != M_LOAD); e.cnt = m_sc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_pattern", 32'(pat), 32'(e.pat));
    chk("sb_step_pulse", 32'(pulse), 32'(e.pulse));
    chk("sb_dir", 32'(dir_o), 32'(e.dir));
    chk("sb_load_ready", 32'(rdy), 32'(e.rdy));
    chk("sb_step_count", 32'(scnt), 32'(e.cnt));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pattern"}, 32'(pat), 32'h00001);
    chk({tag, "_step_pulse"}, 32'(pulse), 32'd0);
    chk({tag, "_dir"}, 32'(dir_o), 32'd0);
    chk({tag, "_step_count"}, 32'(scnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1; modes = 2'b01; sp = 1'b0; run_i = 1'b0; lv = 1'b0; ld = '0;

    // load rows: one accepting cycle; run rows: hold inputs for ncyc edges
    tbl.push_back(mk(0,   9, 2'b01, 0, 1, '0,       18'h00002,  1, 0));
    tbl.push_back(mk(0,   8, 2'b01, 0, 1, '0,       18'h00004,  2, 0));
    tbl.push_back(mk(0, 128, 2'b01, 0, 1, '0,       18'h00001, 18, 0));
    tbl.push_back(mk(1,   1, 2'b11, 0, 1, 18'h20000, 18'h20000, 0, 0));
    tbl.push_back(mk(0,   9, 2'b11, 0, 1, '0,       18'h10000,  1, 1));
    tbl.push_back(mk(0,   8, 2'b01, 0, 1, '0,       18'h20000,  2, 1));
    tbl.push_back(mk(0,   8, 2'b11, 0, 1, '0,       18'h10000,  3, 1));
    tbl.push_back(mk(0,   8, 2'b11, 0, 1, '0,       18'h08000,  4, 1));
    tbl.push_back(mk(1,   1, 2'b11, 0, 1, 18'h00001, 18'h00001, 0, 0));
    tbl.push_back(mk(0,   9, 2'b11, 0, 1, '0,       18'h00002,  1, 0));
    tbl.push_back(mk(1,   1, 2'b11, 0, 1, 18'h00000, 18'h00000, 0, 0));
    tbl.push_back(mk(0,   9, 2'b11, 0, 1, '0,       18'h00000,  1, 0));
    tbl.push_back(mk(0,  16, 2'b11, 0, 1, '0,       18'h00000,  3, 0));
    tbl.push_back(mk(1,   1, 2'b01, 0, 1, 18'h00001, 18'h00001, 0, 0));
    tbl.push_back(mk(0,   8, 2'b01, 0, 1, '0,       18'h00001,  0, 0));
    tbl.push_back(mk(1,   1, 2'b01, 0, 1, 18'h2AAAA, 18'h2AAAA, 0, 0));
    tbl.push_back(mk(0,   8, 2'b01, 0, 1, '0,       18'h2AAAA,  0, 0));
    tbl.push_back(mk(0,   1, 2'b01, 0, 1, '0,       18'h15555,  1, 0));
    tbl.push_back(mk(0,   5, 2'b01, 0, 1, '0,       18'h15555,  1, 0));
    tbl.push_back(mk(0,   1, 2'b01, 1, 1, '0,       18'h2AAAA,  2, 0));
    tbl.push_back(mk(0,   2, 2'b01, 1, 1, '0,       18'h15555,  3, 0));
    tbl.push_back(mk(0,   2, 2'b01, 1, 1, '0,       18'h2AAAA,  4, 0));
    tbl.push_back(mk(0,  10, 2'b00, 1, 1, '0,       18'h2AAAA,  4, 0));
    tbl.push_back(mk(0,   3, 2'b01, 0, 1, '0,       18'h2AAAA,  4, 0));
    tbl.push_back(mk(0,   5, 2'b01, 0, 0, '0,       18'h2AAAA,  4, 0));
    tbl.push_back(mk(0,   8, 2'b01, 0, 1, '0,       18'h2AAAA,  4, 0));
    tbl.push_back(mk(0,   1, 2'b01, 0, 1, '0,       18'h15555,  5, 0));
    tbl.push_back(mk(0,   2, 2'b10, 1, 1, '0,       18'h2AAAA,  6, 0));
    tbl.push_back(mk(0, 500, 2'b01, 1, 1, '0,       18'h2AAAA,  0, 0));

    // reset values while reset is held
    #1;
    chk_reset_vals("rst_hold");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_release_load_ready", 32'(rdy), 32'd1);

    foreach (tbl[i]) begin
      modes = tbl[i].mode; sp = tbl[i].sp; run_i = tbl[i].run;
      if (tbl[i].is_load) begin
        chk($sformatf("row%0d_ready_before_load", i), 32'(rdy), 32'd1);
        lv = 1'b1; ld = tbl[i].data;
        cycle();
        lv = 1'b0; ld = '0;
        chk($sformatf("row%0d_load_ready_low", i), 32'(rdy), 32'd0);
        chk($sformatf("row%0d_no_pulse", i), 32'(pulse), 32'd0);
      end else begin
        for (int c = 0; c < tbl[i].ncyc; c++) cycle();
      end
      chk($sformatf("row%0d_pattern", i), 32'(pat), 32'(tbl[i].e_pat));
      chk($sformatf("row%0d_step_count", i), 32'(scnt), 32'(tbl[i].e_cnt));
      chk($sformatf("row%0d_dir", i), 32'(dir_o), 32'(tbl[i].e_dir));
    end

    // async reset between edges, right after a step edge
    modes = 2'b01; sp = 1'b1; run_i = 1'b1;
    for (int c = 0; c < 4; c++) cycle();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    chk("rst_async_load_ready", 32'(rdy), 32'd1);
    sbq.delete();
    @(posedge clk); #1;
    chk_reset_vals("rst_async_edge");
    rst = 1'b0;
    model_reset();
    sp = 1'b0;
    for (int c = 0; c < 9; c++) cycle();
    chk("post_rst_pattern", 32'(pat), 32'h00002);
    chk("post_rst_step_count", 32'(scnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
